// File: rtl/simple_cpu_if.sv
// Observation bus for simple_cpu: carries the four architectural registers.
//   reg1..reg4 : current values of r0..r3 (8 bits each)
//   master     : driven by the CPU
//   slave      : read by an observer (bench, debug logic)
interface simple_cpu_if;
  logic [7:0] reg1;
  logic [7:0] reg2;
  logic [7:0] reg3;
  logic [7:0] reg4;

  modport master (output reg1, output reg2, output reg3, output reg4);
  modport slave  (input  reg1, input  reg2, input  reg3, input  reg4);
endinterface

// File: rtl/simple_cpu.sv
// Single-cycle 8-bit load/store CPU with a hard-wired 32x16 program ROM,
// four 8-bit registers, a 16x8 data RAM and a 5-bit PC.
//   clk   : system clock, all state updates on the rising edge
//   reset : synchronous active-low reset
//   regs  : observation bus (master), reg1..reg4 = r0..r3
module simple_cpu (
  input  logic         clk,
  input  logic         reset,
  simple_cpu_if.master regs
);
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned PC_W      = 5;
  localparam int unsigned NUM_REGS  = 4;
  localparam int unsigned RAM_DEPTH = 16;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_LDI  = 4'h1, OP_ADD  = 4'h2, OP_SUB  = 4'h3,
    OP_AND  = 4'h4, OP_OR   = 4'h5, OP_XOR  = 4'h6, OP_MOV  = 4'h7,
    OP_ADDI = 4'h8, OP_SHL  = 4'h9, OP_SHR  = 4'hA, OP_LD   = 4'hB,
    OP_ST   = 4'hC, OP_JMP  = 4'hD, OP_BEQZ = 4'hE, OP_HALT = 4'hF
  } opcode_e;

  typedef struct packed {
    opcode_e          op;
    logic [1:0]       rd;
    logic [1:0]       rs;
    logic [DATA_W-1:0] imm;
  } instr_t;

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_e;

  // Hard-wired program image
  function automatic instr_t rom_read(input logic [PC_W-1:0] addr);
    logic [15:0] word;
    case (addr)
      5'd0:    word = 16'h1005;
      5'd1:    word = 16'h1403;
      5'd2:    word = 16'h2100;
      5'd3:    word = 16'h1804;
      5'd4:    word = 16'h8AFF;
      5'd5:    word = 16'h8E03;
      5'd6:    word = 16'hE808;
      5'd7:    word = 16'hD004;
      5'd8:    word = 16'hC001;
      5'd9:    word = 16'hB401;
      5'd10:   word = 16'hF000;
      default: word = 16'h0000;
    endcase
    return instr_t'(word);
  endfunction

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0]   r_q   [NUM_REGS];
  logic [DATA_W-1:0]   r_d   [NUM_REGS];
  logic [DATA_W-1:0]   ram_q [RAM_DEPTH];
  logic [DATA_W-1:0]   ram_d [RAM_DEPTH];
  instr_t              instr_c;
  logic [DATA_W-1:0]   rd_val_c;
  logic [DATA_W-1:0]   rs_val_c;
  logic                exec_c;

  assign instr_c  = rom_read(pc_q);
  assign rd_val_c = r_q[instr_c.rd];
  assign rs_val_c = r_q[instr_c.rs];

  // Run/halt state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Run/halt next state: HALT parks the core until reset
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && instr_c.op == OP_HALT) state_d = ST_HALT;
  end

  // Run/halt output: execute enable
  always_comb begin
    exec_c = 1'b0;
    if (state_q == ST_RUN) exec_c = 1'b1;
  end

  // Execute: next PC, register and RAM write-back
  always_comb begin
    pc_d  = pc_q;
    r_d   = r_q;
    ram_d = ram_q;
    if (exec_c) begin
      pc_d = pc_q + PC_W'(1);
      case (instr_c.op)
        OP_LDI:  r_d[instr_c.rd] = instr_c.imm;
        OP_ADD:  r_d[instr_c.rd] = rd_val_c + rs_val_c;
        OP_SUB:  r_d[instr_c.rd] = rd_val_c - rs_val_c;
        OP_AND:  r_d[instr_c.rd] = rd_val_c & rs_val_c;
        OP_OR:   r_d[instr_c.rd] = rd_val_c | rs_val_c;
        OP_XOR:  r_d[instr_c.rd] = rd_val_c ^ rs_val_c;
        OP_MOV:  r_d[instr_c.rd] = rs_val_c;
        OP_ADDI: r_d[instr_c.rd] = rd_val_c + instr_c.imm;
        OP_SHL:  r_d[instr_c.rd] = {rd_val_c[DATA_W-2:0], 1'b0};
        OP_SHR:  r_d[instr_c.rd] = {1'b0, rd_val_c[DATA_W-1:1]};
        OP_LD:   r_d[instr_c.rd] = ram_q[instr_c.imm[3:0]];
        OP_ST:   ram_d[instr_c.imm[3:0]] = rd_val_c;
        OP_JMP:  pc_d = instr_c.imm[PC_W-1:0];
        OP_BEQZ: if (rd_val_c == '0) pc_d = instr_c.imm[PC_W-1:0];
        OP_HALT: pc_d = pc_q;
        default: ;
      endcase
    end
  end

  // Architectural state registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= '0;
      for (int i = 0; i < NUM_REGS; i++)  r_q[i]   <= '0;
      for (int i = 0; i < RAM_DEPTH; i++) ram_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      r_q   <= r_d;
      ram_q <= ram_d;
    end
  end

  assign regs.reg1 = r_q[0];
  assign regs.reg2 = r_q[1];
  assign regs.reg3 = r_q[2];
  assign regs.reg4 = r_q[3];
endmodule

// File: tb/tb_simple_cpu.sv
// Bench for simple_cpu: a driver steps an ISA-level model alongside the DUT
// and queues the expected register file per edge; a monitor checks it.
module tb_simple_cpu;
  logic clk;
  logic reset;

  simple_cpu_if cpu_regs ();

  simple_cpu dut (
    .clk   (clk),
    .reset (reset),
    .regs  (cpu_regs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [31:0] exp;
    logic [31:0] mask;
    int unsigned tag;
  } sb_t;

  sb_t         sb [$];
  int unsigned cyc_drv  = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // ISA-level reference model
  int m_rom [32];
  int m_r   [4];
  int m_ram [16];
  int m_pc;
  bit m_halt;

  task automatic model_step(input bit rst);
    int ins, op, rd, rs, imm, npc;
    if (!rst) begin
      m_pc = 0;
      m_halt = 1'b0;
      foreach (m_r[i])   m_r[i] = 0;
      foreach (m_ram[i]) m_ram[i] = 0;
      return;
    end
    if (m_halt) return;
    ins = m_rom[m_pc];
    op  = ins / 4096;
    rd  = (ins / 1024) % 4;
    rs  = (ins / 256) % 4;
    imm = ins % 256;
    npc = (m_pc + 1) % 32;
    case (op)
      1:  m_r[rd] = imm;
      2:  m_r[rd] = (m_r[rd] + m_r[rs]) % 256;
      3:  m_r[rd] = (m_r[rd] - m_r[rs] + 256) % 256;
      4:  m_r[rd] = m_r[rd] & m_r[rs];
      5:  m_r[rd] = m_r[rd] | m_r[rs];
      6:  m_r[rd] = m_r[rd] ^ m_r[rs];
      7:  m_r[rd] = m_r[rs];
      8:  m_r[rd] = (m_r[rd] + imm) % 256;
      9:  m_r[rd] = (m_r[rd] * 2) % 256;
      10: m_r[rd] = m_r[rd] / 2;
      11: m_r[rd] = m_ram[imm % 16];
      12: m_ram[imm % 16] = m_r[rd];
      13: npc = imm % 32;
      14: if (m_r[rd] == 0) npc = imm % 32;
      15: begin m_halt = 1'b1; npc = m_pc; end
      default: ;
    endcase
    m_pc = npc;
  endtask

  function automatic logic [31:0] model_view();
    return {8'(m_r[0]), 8'(m_r[1]), 8'(m_r[2]), 8'(m_r[3])};
  endfunction

  // One edge: drive reset at the falling edge, advance the model, queue expectation
  task automatic tick(input bit rst);
    @(negedge clk);
    reset = rst;
    model_step(rst);
    cyc_drv++;
    sb.push_back('{cyc: cyc_drv, exp: model_view(), mask: 32'hFFFF_FFFF, tag: 0});
  endtask

  // Extra fixed-value expectation for the edge just queued by tick()
  task automatic expect_const(input int unsigned tag, input logic [31:0] val,
                              input logic [31:0] mask);
    sb.push_back('{cyc: cyc_drv, exp: val, mask: mask, tag: tag});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  // Monitor: compare every expectation scheduled for this edge
  initial begin
    int unsigned cyc_mon;
    logic [31:0] act;
    sb_t e;
    cyc_mon = 0;
    @(negedge clk);
    forever begin
      @(posedge clk);
      cyc_mon++;
      #1;
      act = {cpu_regs.reg1, cpu_regs.reg2, cpu_regs.reg3, cpu_regs.reg4};
      while (sb.size() > 0 && sb[0].cyc <= cyc_mon) begin
        e = sb.pop_front();
        n_checks++;
        if (e.cyc != cyc_mon) begin
          n_fail++;
          $display("FAIL sched tag=%0d: expectation for edge %0d seen at edge %0d",
                   e.tag, e.cyc, cyc_mon);
        end else if ((act & e.mask) !== (e.exp & e.mask)) begin
          n_fail++;
          if (e.tag == 0)
            $display("FAIL model edge=%0d: regs actual=%08h expected=%08h",
                     cyc_mon, act, e.exp);
          else
            $display("FAIL plan%0d edge=%0d: regs actual=%08h expected=%08h mask=%08h",
                     e.tag, cyc_mon, act & e.mask, e.exp & e.mask, e.mask);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Driver
  initial begin
    foreach (m_rom[i]) m_rom[i] = 0;
    m_rom[0] = 'h1005; m_rom[1] = 'h1403; m_rom[2] = 'h2100; m_rom[3] = 'h1804;
    m_rom[4] = 'h8AFF; m_rom[5] = 'h8E03; m_rom[6] = 'hE808; m_rom[7] = 'hD004;
    m_rom[8] = 'hC001; m_rom[9] = 'hB401; m_rom[10] = 'hF000;
    reset = 1'b0;
    model_step(1'b0);

    // Reset held for three edges
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      expect_const(1, 32'h0000_0000, 32'hFFFF_FFFF);
    end

    // Program start
    tick(1'b1); expect_const(2, 32'h0500_0000, 32'hFF00_0000);
    tick(1'b1); expect_const(3, 32'h0003_0000, 32'h00FF_0000);
    tick(1'b1); expect_const(4, 32'h0800_0000, 32'hFF00_0000);
    run(5);     expect_const(5, 32'h0000_0303, 32'h0000_FFFF);
    run(4);     expect_const(6, 32'h0000_0206, 32'h0000_FFFF);
    run(13);    expect_const(7, 32'h0808_000C, 32'hFFFF_FFFF);

    // Halted: nothing moves
    for (int i = 0; i < 20; i++) begin
      tick(1'b1);
      expect_const(8, 32'h0808_000C, 32'hFFFF_FFFF);
    end

    // Reset mid-loop, then full replay
    tick(1'b0); expect_const(9, 32'h0000_0000, 32'hFFFF_FFFF);
    run(10);
    tick(1'b0); expect_const(10, 32'h0000_0000, 32'hFFFF_FFFF);
    tick(1'b1); expect_const(11, 32'h0500_0000, 32'hFF00_0000);
    run(7);     expect_const(12, 32'h0000_0303, 32'h0000_FFFF);
    run(17);    expect_const(13, 32'h0808_000C, 32'hFFFF_FFFF);

    // Reset while halted restarts from PC 0
    tick(1'b0); expect_const(14, 32'h0000_0000, 32'hFFFF_FFFF);
    tick(1'b1); expect_const(15, 32'h0500_0000, 32'hFF00_0000);
    tick(1'b1); expect_const(16, 32'h0503_0000, 32'hFFFF_0000);

    // Random reset pulses against the model
    for (int i = 0; i < 400; i++) tick($urandom_range(0, 24) != 0);
    tick(1'b0);
    run(30);    expect_const(17, 32'h0808_000C, 32'hFFFF_FFFF);

    @(posedge clk);
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/simple_cpu.md
Name: simple_cpu

Overview:
- Single-cycle 8-bit accumulator-free load/store CPU.
- Contains a hard-wired 32x16 instruction ROM, four 8-bit general registers (r0..r3), a 16x8 data RAM and a 5-bit PC.
- Executes one instruction per clock; all four registers are exported for observation at the top level.

Parameters:
- None. Widths are fixed: data 8 bits, instruction 16 bits, PC 5 bits, data RAM 16 entries.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (sampled on clk rising edge).
- reg1  output  8  current value of r0.
- reg2  output  8  current value of r1.
- reg3  output  8  current value of r2.
- reg4  output  8  current value of r3.

Behaviour:
- Reset: on a rising edge with reset==0, the following clear to 0: PC, r0..r3, all 16 data RAM words, halted flag. reg1..reg4 read 0 from the next edge. Reset has priority over everything, including while halted or mid-loop.
- reg1..reg4 are direct (registered-state) views of r0..r3; no extra latency.
- Each edge with reset==1 and not halted: fetch ROM[PC], execute, write result, update PC. Default next PC is PC+1 mod 32 (31 wraps to 0).
- Instruction format: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm. Arithmetic is mod 256, with no flags.
- 0 NOP.
- 1 LDI: rd=imm.
- 2 ADD: rd=rd+rs.
- 3 SUB: rd=rd-rs.
- 4 AND: rd=rd&rs.
- 5 OR: rd=rd|rs.
- 6 XOR: rd=rd^rs.
- 7 MOV: rd=rs.
- 8 ADDI: rd=rd+imm.
- 9 SHL: rd=rd<<1, 0 fill.
- A SHR: rd=rd>>1 logical.
- B LD: rd=RAM[imm[3:0]].
- C ST: RAM[imm[3:0]]=rd.
- D JMP: PC=imm[4:0].
- E BEQZ: if rd==0 then PC=imm[4:0], else PC+1.
- F HALT: set halted flag; PC and all state frozen until reset.
- rd==rs operands are legal (e.g. SUB r1,r1 gives 0). Register reads use values before the edge.
- RAM reads are combinational; a write is visible to an LD in the next cycle.
- ROM contents (hex), by address:
  - 0: 1005 (LDI r0,5)
  - 1: 1403 (LDI r1,3)
  - 2: 2100 (ADD r0,r1)
  - 3: 1804 (LDI r2,4)
  - 4: 8AFF (ADDI r2,-1)
  - 5: 8E03 (ADDI r3,3)
  - 6: E808 (BEQZ r2,8)
  - 7: D004 (JMP 4)
  - 8: C001 (ST r0,[1])
  - 9: B401 (LD r1,[1])
  - 10: F000 (HALT)
  - 11..31: 0000 (NOP)
- Cycle count: 21 executing edges after reset release reach the end of LD; edge 22 executes HALT.

Test Plan:
- Hold reset=0 for 3 edges -> reg1..reg4 = 00,00,00,00 and remain 0.
- Release reset, check after edges 1, 2, 3 -> reg1=05; reg2=03; reg1=08.
- After edge 8 (first loop pass) -> reg3=03, reg4=03. After edge 12 -> reg3=02, reg4=06.
- After 25 edges -> reg1=08, reg2=08, reg3=00, reg4=0C. Clock 20 more edges -> values unchanged (HALT).
- Assert reset=0 for one edge mid-loop (after edge 10) -> all outputs 00 next edge. Release -> program replays identically, reaching 08,08,00,0C after 25 edges.
- Reset asserted while halted -> outputs clear to 0 and execution restarts at PC 0.
